fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch side of the multi-cycle core: the block that consumes the controller's pc_enable/halt and produces the instruction and opcode the controller decodes. Owns the PC and issues word reads to instruction memory over a valid/ready handshake. Holds the fetched instruction stable until the controller retires it. Stalls the step sequencer while a fetch is outstanding, and traps to an error state on memory timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] ignored (forced 0)
TIMEOUT, 16, max cycles a fetch may wait for mem_ready before error; range 1..255
NOP_INSTR, 32'h0000_0013, value of instr while no valid instruction (addi x0,x0,0)

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high reset
pc_enable  input  1  controller retires current instruction; advance PC and fetch next
halt  input  1  controller has decoded SYSTEM; stop fetching
mem_req  output  1  read request valid
mem_addr  output  32  word-aligned read address (= pc)
mem_ready  input  1  memory accepts the request and returns data this cycle
mem_rdata  input  32  read data, sampled only when mem_req && mem_ready
instr  output  32  current instruction, registered
opcode  output  7  instr[6:0]
pc  output  32  address of instr
stall  output  1  no valid instruction; controller must hold step
halted  output  1  sticky: halt accepted or error
fetch_err  output  1  sticky: fetch timed out

Behaviour:
- Reset (sync, high) values: state=RESET_WAIT, pc=RESET_PC&~3, instr=NOP_INSTR, mem_req=0, stall=1, halted=0, fetch_err=0, wait counter=0. Reset dominates every other input in the same cycle.
- States:
  - RESET_WAIT: one cycle, then FETCH.
  - FETCH: mem_req=1, mem_addr=pc, stall=1, wait counter increments each cycle.
    - On mem_ready: instr<=mem_rdata, counter<=0, go HOLD. Minimum fetch latency is 1 cycle (ready in the first FETCH cycle); stall drops the following cycle.
    - Counter reaching TIMEOUT with no ready: go ERROR.
  - HOLD: mem_req=0, stall=0, instr/pc stable.
    - pc_enable=1: pc<=pc+4 (32-bit wrap, FFFF_FFFC -> 0000_0000), instr<=NOP_INSTR, go FETCH.
    - halt=1 (takes priority over pc_enable): go HALTED.
  - HALTED: mem_req=0, stall=1, halted=1; instr and pc frozen at the SYSTEM instruction. Exit only by reset.
  - ERROR: mem_req=0, stall=1, halted=1, fetch_err=1, instr=NOP_INSTR, pc frozen at the faulting address. Exit only by reset.
- Handshake: while mem_req=1, mem_addr is stable until a ready cycle; no second request before the first completes. mem_rdata is ignored when mem_ready=0 or mem_req=0.
- pc_enable or halt outside HOLD: ignored. No state change.
- Reset during FETCH: mem_req=0 from the next cycle. The memory must tolerate an abandoned request.
- mem_ready asserted while mem_req=0: ignored.
- pc[1:0] is always 0. No misaligned fetch is possible.
- opcode is combinational from instr; every other output is registered or decoded from state.

Decomposition:
- Shared core package: opcode constants (OP_IMM, OP, SYSTEM), NOP_INSTR, XLEN=32, fetch state enum (RESET_WAIT, FETCH, HOLD, HALTED, ERROR).
- One natural sub-module: fetch_timer, an 8-bit wait counter with clear/enable inputs and an expired output compared against TIMEOUT. Everything else stays in fetch_unit.

Test Plan:
- Reset release, memory returns 32'h00500093 with ready on the first FETCH cycle -> mem_addr=0; instr=00500093 and opcode=0010011 one cycle later; stall=0.
- In HOLD, pulse pc_enable; memory delays ready by 3 cycles -> pc=4, mem_req held 4 cycles with mem_addr=4 stable; stall=1 throughout; instr=NOP until data arrives.
- Fetch 32'h00000073, then assert halt and pc_enable together -> HALTED; halted=1; pc unchanged; no further mem_req for 20 cycles.
- mem_ready never asserts, TIMEOUT=16 -> after 16 FETCH cycles fetch_err=1, halted=1, mem_req=0; reset clears all three.
- RESET_PC=32'hFFFF_FFFC, fetch, then pc_enable -> next mem_addr=0000_0000.
- Assert reset in the 2nd cycle of a pending fetch -> mem_req=0 the next cycle; pc=RESET_PC; a fresh fetch starts after RESET_WAIT.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch side: data width, opcode constants, and the
// fetch sequencer state encoding.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        StResetWait,
        StFetch,
        StHold,
        StHalted,
        StError
    } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// Wait counter for an outstanding fetch; expired_o flags the last allowed wait cycle.
module fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Counter holds the number of completed wait cycles, so the TIMEOUT-th cycle sees TIMEOUT-1.
    localparam logic [7:0] Limit = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == Limit);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads instruction memory over valid/ready, and holds the
// fetched word until the controller retires or halts on it.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     TIMEOUT   = 16,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            pc_enable_i,
    input  logic            halt_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_ready_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic [6:0]      opcode_o,
    output logic [XLEN-1:0] pc_o,
    output logic            stall_o,
    output logic            halted_o,
    output logic            fetch_err_o
);

    localparam logic [XLEN-1:0] ResetPcAligned = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            in_fetch;
    logic            timer_expired;

    assign in_fetch = (state_q == StFetch);

    fetch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (!in_fetch || mem_ready_i),
        .enable_i (in_fetch),
        .expired_o(timer_expired)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StResetWait;
            pc_q    <= ResetPcAligned;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            StResetWait: state_d = StFetch;
            StFetch: begin
                if (mem_ready_i) begin
                    instr_d = mem_rdata_i;
                    state_d = StHold;
                end else if (timer_expired) begin
                    instr_d = NOP_INSTR;
                    state_d = StError;
                end
            end
            StHold: begin
                // halt wins: the SYSTEM instruction and its PC stay visible
                if (halt_i) begin
                    state_d = StHalted;
                end else if (pc_enable_i) begin
                    pc_d    = pc_q + 32'd4;
                    instr_d = NOP_INSTR;
                    state_d = StFetch;
                end
            end
            StHalted: state_d = StHalted;
            StError:  state_d = StError;
            default:  state_d = StResetWait;
        endcase
    end

    always_comb begin
        mem_req_o   = in_fetch;
        mem_addr_o  = pc_q;
        stall_o     = (state_q != StHold);
        halted_o    = (state_q == StHalted) || (state_q == StError);
        fetch_err_o = (state_q == StError);
        instr_o     = instr_q;
        pc_o        = pc_q;
        opcode_o    = instr_q[6:0];
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default instance plus a wrap-around / short-timeout instance.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    int   n_asserts = 0;
    int   n_fail    = 0;

    // Default instance
    logic        reset, pc_enable, halt, mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req, stall, halted, fetch_err;
    logic [31:0] mem_addr, instr, pc;
    logic [6:0]  opcode;

    // RESET_PC with low bits set, TIMEOUT=1
    logic        w_reset, w_pc_enable, w_halt, w_mem_ready;
    logic [31:0] w_mem_rdata;
    logic        w_mem_req, w_stall, w_halted, w_fetch_err;
    logic [31:0] w_mem_addr, w_instr, w_pc;
    logic [6:0]  w_opcode;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16),
        .NOP_INSTR(32'h0000_0013)
    ) u_dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .pc_enable_i(pc_enable),
        .halt_i     (halt),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_ready_i(mem_ready),
        .mem_rdata_i(mem_rdata),
        .instr_o    (instr),
        .opcode_o   (opcode),
        .pc_o       (pc),
        .stall_o    (stall),
        .halted_o   (halted),
        .fetch_err_o(fetch_err)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFFF),
        .TIMEOUT  (1),
        .NOP_INSTR(32'h0000_0013)
    ) u_wrap (
        .clk_i      (clk),
        .reset_i    (w_reset),
        .pc_enable_i(w_pc_enable),
        .halt_i     (w_halt),
        .mem_req_o  (w_mem_req),
        .mem_addr_o (w_mem_addr),
        .mem_ready_i(w_mem_ready),
        .mem_rdata_i(w_mem_rdata),
        .instr_o    (w_instr),
        .opcode_o   (w_opcode),
        .pc_o       (w_pc),
        .stall_o    (w_stall),
        .halted_o   (w_halted),
        .fetch_err_o(w_fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic saw_req;
        logic early_err;

        reset = 1'b1; pc_enable = 1'b0; halt = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        w_reset = 1'b1; w_pc_enable = 1'b0; w_halt = 1'b0; w_mem_ready = 1'b0;
        w_mem_rdata = 32'h0;
        step();
        step();

        // Reset state
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc", pc, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);

        // First fetch, ready in first FETCH cycle
        reset = 1'b0;
        step();
        check("f1_req", 32'(mem_req), 32'd1);
        check("f1_addr", mem_addr, 32'h0);
        check("f1_stall", 32'(stall), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        check("f1_instr", instr, 32'h0050_0093);
        check("f1_opcode", 32'(opcode), 32'(OP_IMM));
        check("f1_stall_lo", 32'(stall), 32'd0);
        check("f1_req_lo", 32'(mem_req), 32'd0);

        // Retire, ready delayed so the request spans 4 cycles
        pc_enable = 1'b1;
        step();
        pc_enable = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("f2_req_c%0d", c), 32'(mem_req), 32'd1);
            check($sformatf("f2_addr_c%0d", c), mem_addr, 32'h4);
            check($sformatf("f2_stall_c%0d", c), 32'(stall), 32'd1);
            check($sformatf("f2_instr_c%0d", c), instr, NOP);
            if (c == 4) begin
                mem_ready = 1'b1; mem_rdata = 32'h0000_0073;
            end
            step();
        end
        mem_ready = 1'b0;
        check("f2_pc", pc, 32'h4);
        check("f2_instr", instr, 32'h0000_0073);
        check("f2_opcode", 32'(opcode), 32'(SYSTEM));

        // halt and pc_enable together: halt wins
        halt = 1'b1; pc_enable = 1'b1;
        step();
        halt = 1'b0; pc_enable = 1'b0;
        check("h_halted", 32'(halted), 32'd1);
        check("h_pc", pc, 32'h4);
        check("h_stall", 32'(stall), 32'd1);
        check("h_instr", instr, 32'h0000_0073);
        check("h_err", 32'(fetch_err), 32'd0);
        saw_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            pc_enable = c[0];
            mem_ready = 1'b1;
            mem_rdata = 32'h1234_5678;
            if (mem_req) saw_req = 1'b1;
            step();
        end
        pc_enable = 1'b0; mem_ready = 1'b0;
        check("h_no_req", 32'(saw_req), 32'd0);
        check("h_pc_frozen", pc, 32'h4);
        check("h_instr_frozen", instr, 32'h0000_0073);

        // Timeout after exactly 16 unanswered FETCH cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        early_err = 1'b0;
        saw_req = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            if (fetch_err) early_err = 1'b1;
            if (!mem_req) saw_req = 1'b0;
            step();
        end
        check("to_no_early_err", 32'(early_err), 32'd0);
        check("to_req_held", 32'(saw_req), 32'd1);
        check("to_err", 32'(fetch_err), 32'd1);
        check("to_halted", 32'(halted), 32'd1);
        check("to_req", 32'(mem_req), 32'd0);
        check("to_instr", instr, NOP);
        check("to_pc", pc, 32'h0);
        reset = 1'b1;
        step();
        check("to_rst_err", 32'(fetch_err), 32'd0);
        check("to_rst_halted", 32'(halted), 32'd0);
        check("to_rst_req", 32'(mem_req), 32'd0);

        // Reset in the 2nd cycle of a pending fetch at pc=4
        reset = 1'b0;
        step();
        mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        step();
        mem_ready = 1'b0;
        pc_enable = 1'b1;
        step();
        pc_enable = 1'b0;
        check("ra_addr", mem_addr, 32'h4);
        step();
        check("ra_req_c2", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ra_req_dropped", 32'(mem_req), 32'd0);
        check("ra_pc", pc, 32'h0);
        check("ra_stall", 32'(stall), 32'd1);
        step();
        check("ra_refetch_req", 32'(mem_req), 32'd1);
        check("ra_refetch_addr", mem_addr, 32'h0);

        // Wrap instance: low PC bits dropped, +4 wraps to zero, TIMEOUT=1
        w_reset = 1'b0;
        step();
        check("w_addr", w_mem_addr, 32'hFFFF_FFFC);
        check("w_pc", w_pc, 32'hFFFF_FFFC);
        w_mem_ready = 1'b1; w_mem_rdata = 32'h0020_81B3;
        step();
        w_mem_ready = 1'b0;
        check("w_instr", w_instr, 32'h0020_81B3);
        check("w_opcode", 32'(w_opcode), 32'(OP));
        check("w_stall", 32'(w_stall), 32'd0);
        w_pc_enable = 1'b1;
        step();
        w_pc_enable = 1'b0;
        check("w_wrap_addr", w_mem_addr, 32'h0000_0000);
        check("w_wrap_req", 32'(w_mem_req), 32'd1);
        check("w_err_pre", 32'(w_fetch_err), 32'd0);
        step();
        check("w_t1_err", 32'(w_fetch_err), 32'd1);
        check("w_t1_halted", 32'(w_halted), 32'd1);
        check("w_t1_pc", w_pc, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
